ids_trace_scheduler: RTL and testbench

IDS_TRACE_SCHEDULER -- requirements
Module: ids_trace_scheduler

---
 rtl/ids_trace_scheduler.sv | 159 +++++++++++++++
 tb/tb_ids_trace_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ids_trace_scheduler.sv
// ids_trace_scheduler
// Drives one codeword at a time into an external IDS channel generator and
// collects N noisy traces of it, one fresh generator sample per trace.
//
// Ports:
//   clk, rst           sole clock; asynchronous active-high reset
//   in_valid/in_ready  upstream codeword handshake (ready only while idle)
//   in_data            codeword to transmit
//   num_traces         traces wanted for the codeword (0 means 1)
//   gen_data_in        latched codeword presented to the generator
//   gen_n_out          generator output length (signed)
//   gen_data_out       generator output bits
//   out_valid/ready    downstream trace handshake
//   out_data, out_len  captured trace bits and clamped length
//   out_trace_idx      0-based trace index within the codeword
//   out_last           final trace of the codeword
//   err_len            sticky flag: an out-of-range length was captured
//   word_count         completed codewords (wrapping)
module ids_trace_scheduler #(
  parameter int unsigned K          = 5,
  parameter int          DATA_WIDTH = 32,
  parameter int unsigned GEN_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [K-1:0]          in_data,
  input  logic [3:0]            num_traces,
  output logic [K-1:0]          gen_data_in,
  input  logic signed [31:0]    gen_n_out,
  input  logic [DATA_WIDTH-1:0] gen_data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [5:0]            out_len,
  output logic [3:0]            out_trace_idx,
  output logic                  out_last,
  output logic                  err_len,
  output logic [15:0]           word_count
);

  typedef enum logic [1:0] {StIdle, StWait, StEmit} state_e;

  // Generator sample is valid on the edge where the latency counter reaches this value.
  localparam logic [3:0] LatLast = 4'(GEN_LAT - 1);

  state_e                state_q, state_d;
  logic [K-1:0]          gen_data_q, gen_data_d;
  logic [3:0]            n_q, n_d;
  logic [3:0]            idx_q, idx_d;
  logic [3:0]            lat_q, lat_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [5:0]            out_len_q, out_len_d;
  logic [3:0]            out_idx_q, out_idx_d;
  logic                  out_last_q, out_last_d;
  logic                  err_q, err_d;
  logic [15:0]           word_q, word_d;

  logic                  len_neg, len_big;
  logic [5:0]            len_clamped;

  always_comb begin
    len_neg     = gen_n_out < 0;
    len_big     = gen_n_out > DATA_WIDTH;
    len_clamped = len_neg ? 6'd0 : (len_big ? 6'(DATA_WIDTH) : gen_n_out[5:0]);
  end

  always_comb begin
    state_d    = state_q;
    gen_data_d = gen_data_q;
    n_d        = n_q;
    idx_d      = idx_q;
    lat_d      = lat_q;
    out_data_d = out_data_q;
    out_len_d  = out_len_q;
    out_idx_d  = out_idx_q;
    out_last_d = out_last_q;
    err_d      = err_q;
    word_d     = word_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          gen_data_d = in_data;
          n_d        = (num_traces == 4'd0) ? 4'd1 : num_traces;
          idx_d      = 4'd0;
          lat_d      = 4'd0;
          state_d    = StWait;
        end
      end
      StWait: begin
        lat_d = lat_q + 4'd1;
        if (lat_q == LatLast) begin
          out_data_d = gen_data_out;
          out_len_d  = len_clamped;
          out_idx_d  = idx_q;
          out_last_d = (idx_q == n_q - 4'd1);
          if (len_neg || len_big) begin
            err_d = 1'b1;
          end
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (out_ready) begin
          if (idx_q == n_q - 4'd1) begin
            word_d  = word_q + 16'd1;
            state_d = StIdle;
          end else begin
            // Next trace needs a fresh generator sample.
            idx_d   = idx_q + 4'd1;
            lat_d   = 4'd0;
            state_d = StWait;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      gen_data_q <= '0;
      n_q        <= '0;
      idx_q      <= '0;
      lat_q      <= '0;
      out_data_q <= '0;
      out_len_q  <= '0;
      out_idx_q  <= '0;
      out_last_q <= 1'b0;
      err_q      <= 1'b0;
      word_q     <= '0;
    end else begin
      state_q    <= state_d;
      gen_data_q <= gen_data_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      lat_q      <= lat_d;
      out_data_q <= out_data_d;
      out_len_q  <= out_len_d;
      out_idx_q  <= out_idx_d;
      out_last_q <= out_last_d;
      err_q      <= err_d;
      word_q     <= word_d;
    end
  end

  assign in_ready      = (state_q == StIdle);
  assign out_valid     = (state_q == StEmit);
  assign gen_data_in   = gen_data_q;
  assign out_data      = out_data_q;
  assign out_len       = out_len_q;
  assign out_trace_idx = out_idx_q;
  assign out_last      = out_last_q;
  assign err_len       = err_q;
  assign word_count    = word_q;

endmodule

// File: tb/tb_ids_trace_scheduler.sv
// Bench for ids_trace_scheduler. The generator is modelled as
// gen_data_out = {edge counter, gen_data_in}, so each captured trace carries the
// cycle it was sampled in; expected traces are queued at stimulus time.
module tb_ids_trace_scheduler;

  typedef struct {
    logic [31:0] data;
    logic [5:0]  len;
    logic [3:0]  idx;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_valid3;
  logic [4:0]  in_data;
  logic [3:0]  num_traces;
  int          gn;
  logic        out_ready;

  logic        in_ready, out_valid, out_last, err_len;
  logic [4:0]  gen_data_in;
  logic [31:0] gen_data_out, out_data;
  logic [5:0]  out_len;
  logic [3:0]  out_trace_idx;
  logic [15:0] word_count;

  logic        in_ready3, out_valid3, out_last3, err_len3;
  logic [4:0]  gen_data_in3;
  logic [31:0] gen_data_out3, out_data3;
  logic [5:0]  out_len3;
  logic [3:0]  out_trace_idx3;
  logic [15:0] word_count3;

  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;
  exp_t        sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign gen_data_out  = {cyc[26:0], gen_data_in};
  assign gen_data_out3 = {cyc[26:0], gen_data_in3};

  ids_trace_scheduler #(.K(5), .DATA_WIDTH(32), .GEN_LAT(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .num_traces(num_traces), .gen_data_in(gen_data_in), .gen_n_out(gn),
    .gen_data_out(gen_data_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_len(out_len), .out_trace_idx(out_trace_idx),
    .out_last(out_last), .err_len(err_len), .word_count(word_count)
  );

  ids_trace_scheduler #(.K(5), .DATA_WIDTH(32), .GEN_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data),
    .num_traces(num_traces), .gen_data_in(gen_data_in3), .gen_n_out(gn),
    .gen_data_out(gen_data_out3), .out_valid(out_valid3), .out_ready(out_ready),
    .out_data(out_data3), .out_len(out_len3), .out_trace_idx(out_trace_idx3),
    .out_last(out_last3), .err_len(err_len3), .word_count(word_count3)
  );

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Queue one expected trace captured at edge cap_edge (the DUT sees cyc = cap_edge-1).
  task automatic push(int unsigned cap_edge, logic [4:0] cw, int g, int idx, int n);
    exp_t        e;
    logic [31:0] t;
    t      = cap_edge - 1;
    e.data = {t[26:0], cw};
    e.len  = (g < 0) ? 6'd0 : ((g > 32) ? 6'd32 : 6'(g));
    e.idx  = 4'(idx);
    e.last = (idx == n - 1);
    sb.push_back(e);
  endtask

  // Called just after a negedge; returns just after the negedge following the accept edge.
  task automatic accept(logic [4:0] cw, logic [3:0] nt, output int unsigned acc);
    in_valid   = 1'b1;
    in_data    = cw;
    num_traces = nt;
    acc        = cyc + 1;
    @(negedge clk);
    in_valid   = 1'b0;
  endtask

  // Wait (bounded) for a handshake, compare it against the queue head.
  task automatic collect(string tag);
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      if (out_valid && out_ready) break;
      @(negedge clk);
    end
    if (!(out_valid && out_ready)) begin
      check({tag, "_timeout"}, 64'(out_valid), 64'd1);
      return;
    end
    if (sb.size() == 0) begin
      check({tag, "_unexpected"}, 64'(sb.size()), 64'd1);
      @(negedge clk);
      return;
    end
    e = sb.pop_front();
    check({tag, "_data"}, 64'(out_data), 64'(e.data));
    check({tag, "_len"}, 64'(out_len), 64'(e.len));
    check({tag, "_idx"}, 64'(out_trace_idx), 64'(e.idx));
    check({tag, "_last"}, 64'(out_last), 64'(e.last));
    @(negedge clk);
  endtask

  task automatic check_reset_values(string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_data"}, 64'(out_data), 64'd0);
    check({tag, "_out_len"}, 64'(out_len), 64'd0);
    check({tag, "_out_idx"}, 64'(out_trace_idx), 64'd0);
    check({tag, "_out_last"}, 64'(out_last), 64'd0);
    check({tag, "_gen_data_in"}, 64'(gen_data_in), 64'd0);
    check({tag, "_err_len"}, 64'(err_len), 64'd0);
    check({tag, "_word_count"}, 64'(word_count), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_valid3  = 1'b0;
    in_data    = '0;
    num_traces = '0;
    gn         = 20;
    out_ready  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_reset_values("reset");
    check("reset_in_ready3", 64'(in_ready3), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    // Three traces of codeword 13, out_ready held high.
    accept(5'd13, 4'd3, acc);
    for (int k = 0; k < 3; k++) push(acc + 1 + 2 * k, 5'd13, 20, k, 3);
    collect("w1t0");
    collect("w1t1");
    collect("w1t2");
    check("w1_in_ready", 64'(in_ready), 64'd1);
    check("w1_out_valid_low", 64'(out_valid), 64'd0);
    check("w1_word_count", 64'(word_count), 64'd1);
    check("w1_gen_hold", 64'(gen_data_in), 64'd13);

    // num_traces=0 gives one trace; inputs changed while busy are ignored.
    in_valid   = 1'b1;
    in_data    = 5'd31;
    num_traces = 4'd0;
    acc        = cyc + 1;
    @(negedge clk);
    in_data    = 5'd7;
    num_traces = 4'd5;
    @(negedge clk);
    in_valid   = 1'b0;
    push(acc + 1, 5'd31, 20, 0, 1);
    collect("w2t0");
    check("w2_word_count", 64'(word_count), 64'd2);
    check("w2_gen_hold", 64'(gen_data_in), 64'd31);
    check("w2_idle", 64'(in_ready), 64'd1);

    // Stall: outputs hold while the generator keeps changing.
    out_ready = 1'b0;
    gn        = 10;
    accept(5'd9, 4'd1, acc);
    push(acc + 1, 5'd9, 10, 0, 1);
    @(negedge clk);
    gn = 3;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_data", 64'(out_data), 64'(sb[0].data));
      check("stall_len", 64'(out_len), 64'd10);
      @(negedge clk);
    end
    out_ready = 1'b1;
    collect("w3t0");
    check("w3_word_count", 64'(word_count), 64'd3);
    check("w3_err_clear", 64'(err_len), 64'd0);

    // Length clamping, high then negative.
    out_ready = 1'b0;
    gn        = 40;
    accept(5'd21, 4'd2, acc);
    push(acc + 1, 5'd21, 40, 0, 2);
    @(negedge clk);
    check("clamp_hi_err", 64'(err_len), 64'd1);
    check("clamp_hi_len", 64'(out_len), 64'd32);
    gn        = -1;
    out_ready = 1'b1;
    push(acc + 3, 5'd21, -1, 1, 2);
    collect("w4t0");
    collect("w4t1");
    check("clamp_lo_err_sticky", 64'(err_len), 64'd1);
    check("w4_word_count", 64'(word_count), 64'd4);

    // Reset while trace 1 of 4 is being offered.
    gn = 12;
    accept(5'd5, 4'd4, acc);
    push(acc + 1, 5'd5, 12, 0, 4);
    collect("w5t0");
    out_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    check("pre_rst_idx", 64'(out_trace_idx), 64'd1);
    #1 rst = 1'b1;
    #1 check_reset_values("midrst");
    @(negedge clk);
    check("in_rst_no_emit", 64'(out_valid), 64'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    accept(5'd3, 4'd2, acc);
    push(acc + 1, 5'd3, 12, 0, 2);
    push(acc + 3, 5'd3, 12, 1, 2);
    collect("w6t0");
    collect("w6t1");
    check("w6_word_count", 64'(word_count), 64'd1);
    check("w6_err_after_rst", 64'(err_len), 64'd0);

    // GEN_LAT=3: out_valid after edges acc+3 and acc+7 only.
    in_valid3  = 1'b1;
    in_data    = 5'd11;
    num_traces = 4'd2;
    @(negedge clk);
    in_valid3  = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check($sformatf("lat3_valid_k%0d", k), 64'(out_valid3), 64'((k == 3) || (k == 7)));
      if (k == 7) begin
        check("lat3_idx", 64'(out_trace_idx3), 64'd1);
        check("lat3_last", 64'(out_last3), 64'd1);
      end
    end
    check("lat3_word_count", 64'(word_count3), 64'd1);
    check("lat3_idle", 64'(in_ready3), 64'd1);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
